// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its requesters and the 1-port memory.
// slave = arbiter side, master = requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_SIZE_P = 16,
    parameter int unsigned SB_ENTRY    = 8
);
    localparam int unsigned OCC_W = $clog2(SB_ENTRY) + 1;

    // execute-stage load path
    logic                   ld_v_i;
    logic [WORD_SIZE_P-1:0] ld_addr_i;
    logic                   ld_ready_o;
    logic                   ld_resp_v_o;
    logic [WORD_SIZE_P-1:0] ld_resp_data_o;

    // store-buffer drain path
    logic                   st_v_i;
    logic [WORD_SIZE_P-1:0] st_addr_i;
    logic [WORD_SIZE_P-1:0] st_data_i;
    logic                   st_ready_o;
    logic [OCC_W-1:0]       sb_occupancy_i;
    logic                   flush_i;

    // single memory port
    logic                   mem_v_o;
    logic                   mem_w_o;
    logic [WORD_SIZE_P-1:0] mem_addr_o;
    logic [WORD_SIZE_P-1:0] mem_data_o;
    logic [WORD_SIZE_P-1:0] mem_data_i;

    modport slave (
        input  ld_v_i, ld_addr_i, st_v_i, st_addr_i, st_data_i,
               sb_occupancy_i, flush_i, mem_data_i,
        output ld_ready_o, ld_resp_v_o, ld_resp_data_o, st_ready_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o
    );

    modport master (
        output ld_v_i, ld_addr_i, st_v_i, st_addr_i, st_data_i,
               sb_occupancy_i, flush_i, mem_data_i,
        input  ld_ready_o, ld_resp_v_o, ld_resp_data_o, st_ready_o,
               mem_v_o, mem_w_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Load/store-drain arbiter for the single data-memory port: loads win by default,
// starvation or store-buffer high water forces drain. ARB_PERF_CNT_EN adds grant counters.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE_P    = 16,
    parameter int unsigned SB_ENTRY       = 8,
    parameter int unsigned STARVE_LIMIT_P = 4,
    parameter int unsigned HIGH_WATER_P   = 6,
    parameter int unsigned LOW_WATER_P    = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    mem_port_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ld_grants_o,
    output logic [31:0]        perf_st_grants_o,
    output logic [31:0]        perf_forced_drain_o
`endif
);
    localparam int unsigned OCC_W  = $clog2(SB_ENTRY) + 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERF_W = 32;

    typedef enum logic {
        LD_PRI = 1'b0,
        ST_PRI = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_ld_pend;

    logic             w_ld_req;
    logic             w_st_req;
    logic             w_ld_gnt;
    logic             w_st_gnt;
    logic             w_st_denied;
    logic [CNT_W:0]   w_starve_inc;
    logic [CNT_W-1:0] w_starve_sat;
    logic             w_high_water;
    logic             w_force_drain;
    logic             w_drain_done;
    logic             w_ld_resp_v;

    // Grant selection; reset_n_i gating keeps every grant low while in reset.
    always_comb begin
        w_ld_req = bus.ld_v_i && !bus.flush_i && reset_n_i;
        w_st_req = bus.st_v_i && reset_n_i;
        w_ld_gnt = 1'b0;
        w_st_gnt = 1'b0;
        if (r_state == ST_PRI) begin
            w_st_gnt = w_st_req;
            w_ld_gnt = w_ld_req && !w_st_req;
        end else begin
            w_ld_gnt = w_ld_req;
            w_st_gnt = w_st_req && !w_ld_req;
        end
    end

    always_comb begin
        w_st_denied   = bus.st_v_i && !w_st_gnt;
        w_starve_inc  = {1'b0, r_starve_cnt} + (CNT_W+1)'(1);
        w_starve_sat  = (r_starve_cnt == {CNT_W{1'b1}}) ? r_starve_cnt
                                                        : r_starve_cnt + CNT_W'(1);
        w_high_water  = (bus.sb_occupancy_i >= OCC_W'(HIGH_WATER_P)) ||
                        (bus.sb_occupancy_i == OCC_W'(SB_ENTRY));
        w_force_drain = bus.st_v_i &&
                        ((w_st_denied && (w_starve_inc >= (CNT_W+1)'(STARVE_LIMIT_P))) ||
                         w_high_water);
        // Occupancy seen here is pre-pop, hence the +1.
        w_drain_done  = !bus.st_v_i ||
                        (w_st_gnt && (bus.sb_occupancy_i <= OCC_W'(LOW_WATER_P + 1)));
    end

    assign bus.ld_ready_o = w_ld_gnt;
    assign bus.st_ready_o = w_st_gnt;
    assign bus.mem_v_o    = w_ld_gnt || w_st_gnt;
    assign bus.mem_w_o    = w_st_gnt;
    assign bus.mem_addr_o = w_st_gnt ? bus.st_addr_i :
                            w_ld_gnt ? bus.ld_addr_i : '0;
    assign bus.mem_data_o = w_st_gnt ? bus.st_data_i : '0;

    // Read data arrives the cycle after the grant; a flush in that cycle squashes it.
    assign w_ld_resp_v        = r_ld_pend && !bus.flush_i;
    assign bus.ld_resp_v_o    = w_ld_resp_v;
    assign bus.ld_resp_data_o = w_ld_resp_v ? bus.mem_data_i : '0;

    // Priority state, starvation counter and load-response tracking.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= LD_PRI;
            r_starve_cnt <= '0;
            r_ld_pend    <= 1'b0;
        end else begin
            r_ld_pend <= w_ld_gnt;
            case (r_state)
                LD_PRI: begin
                    if (w_force_drain) begin
                        r_state      <= ST_PRI;
                        r_starve_cnt <= '0;
                    end else if (w_st_denied) begin
                        r_starve_cnt <= w_starve_sat;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_PRI: begin
                    if (w_drain_done) begin
                        r_state <= LD_PRI;
                    end
                    r_starve_cnt <= w_st_denied ? w_starve_sat : '0;
                end
                default: begin
                    r_state      <= LD_PRI;
                    r_starve_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_ld;
    logic [PERF_W-1:0] r_perf_st;
    logic [PERF_W-1:0] r_perf_fd;
    logic              w_fd_event;

    assign w_fd_event = (r_state == LD_PRI) && w_force_drain;

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_perf_ld <= '0;
            r_perf_st <= '0;
            r_perf_fd <= '0;
        end else begin
            if (w_ld_gnt && (r_perf_ld != {PERF_W{1'b1}})) r_perf_ld <= r_perf_ld + PERF_W'(1);
            if (w_st_gnt && (r_perf_st != {PERF_W{1'b1}})) r_perf_st <= r_perf_st + PERF_W'(1);
            if (w_fd_event && (r_perf_fd != {PERF_W{1'b1}})) r_perf_fd <= r_perf_fd + PERF_W'(1);
        end
    end

    assign perf_ld_grants_o    = r_perf_ld;
    assign perf_st_grants_o    = r_perf_st;
    assign perf_forced_drain_o = r_perf_fd;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level priority/occupancy model and a shadow memory.
module tb_mem_port_arbiter;
    localparam int unsigned W      = 16;
    localparam int unsigned SBE    = 8;
    localparam int unsigned STARVE = 4;
    localparam int unsigned HIGH   = 6;
    localparam int unsigned LOW    = 2;
    localparam int unsigned OW     = $clog2(SBE) + 1;

    logic clk_i = 1'b0;
    logic reset_n_i;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.WORD_SIZE_P(W), .SB_ENTRY(SBE)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_ld;
    logic [31:0] perf_st;
    logic [31:0] perf_fd;
`endif

    mem_port_arbiter #(
        .WORD_SIZE_P(W), .SB_ENTRY(SBE), .STARVE_LIMIT_P(STARVE),
        .HIGH_WATER_P(HIGH), .LOW_WATER_P(LOW)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_ld_grants_o    (perf_ld),
        .perf_st_grants_o    (perf_st),
        .perf_forced_drain_o (perf_fd)
`endif
    );

    // Environment memory: synchronous, one-cycle read latency.
    function automatic logic [W-1:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    logic [W-1:0] env_mem [0:255];
    bit           env_wr  [0:255];

    always @(posedge clk_i) begin
        if (bus.mem_v_o) begin
            if (bus.mem_w_o) begin
                env_mem[bus.mem_addr_o[7:0]] <= bus.mem_data_o;
                env_wr[bus.mem_addr_o[7:0]]  <= 1'b1;
            end else begin
                bus.mem_data_i <= env_wr[bus.mem_addr_o[7:0]] ? env_mem[bus.mem_addr_o[7:0]]
                                                               : init_word(bus.mem_addr_o[7:0]);
            end
        end
    end

    // Reference model: who has priority, how long stores have waited, what a load returns.
    bit           m_forced;
    int           m_denied;
    bit           m_pend;
    logic [W-1:0] m_pend_data;
    logic [W-1:0] ref_mem [0:255];

    function automatic void model_reset();
        m_forced = 1'b0;
        m_denied = 0;
        m_pend   = 1'b0;
    endfunction

    function automatic void model_grant(input bit ldv, input bit stv, input bit fl,
                                        output bit g_ld, output bit g_st);
        bit ld_ok;
        ld_ok = ldv && !fl;
        if (m_forced) begin
            g_st = stv;
            g_ld = ld_ok && !stv;
        end else begin
            g_ld = ld_ok;
            g_st = stv && !ld_ok;
        end
    endfunction

    function automatic void model_clock(input bit stv, input int occ, input bit g_ld, input bit g_st,
                                        input logic [W-1:0] la, input logic [W-1:0] sa,
                                        input logic [W-1:0] sd);
        m_pend = g_ld;
        if (g_ld) m_pend_data = ref_mem[la[7:0]];
        if (g_st) ref_mem[sa[7:0]] = sd;
        if (!m_forced) begin
            if (stv && ((!g_st && (m_denied + 1 >= int'(STARVE))) || occ >= int'(HIGH) || occ == int'(SBE))) begin
                m_forced = 1'b1;
                m_denied = 0;
            end else if (stv && !g_st) begin
                m_denied = (m_denied < 15) ? m_denied + 1 : 15;
            end else begin
                m_denied = 0;
            end
        end else begin
            if (!stv || (g_st && occ <= int'(LOW) + 1)) m_forced = 1'b0;
            m_denied = 0;
        end
    endfunction

    task automatic drive_idle();
        bus.ld_v_i         = 1'b0;
        bus.ld_addr_i      = '0;
        bus.st_v_i         = 1'b0;
        bus.st_addr_i      = '0;
        bus.st_data_i      = '0;
        bus.sb_occupancy_i = '0;
        bus.flush_i        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [52:0] all_outs();
        return {bus.ld_ready_o, bus.st_ready_o, bus.mem_v_o, bus.mem_w_o, bus.mem_addr_o,
                bus.mem_data_o, bus.ld_resp_v_o, bus.ld_resp_data_o};
    endfunction

    task automatic test_reset();
        logic [52:0] o;
        logic [W+1:0] r;
        reset_n_i = 1'b0;
        drive_idle();
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0010;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h0080; bus.sb_occupancy_i = OW'(2);
        @(negedge clk_i);
        o = all_outs();
        n_total++;
        if (o !== 53'd0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", o); end
        @(posedge clk_i); #1;
        bus.st_v_i = 1'b0;
        reset_n_i  = 1'b1;
        @(negedge clk_i);
        r = {bus.ld_ready_o, bus.mem_w_o, bus.mem_addr_o};
        n_total++;
        if (r !== {1'b1, 1'b0, 16'h0010}) begin n_bad++; $display("FAIL reset_first_load: got %h want %h", r, {1'b1, 1'b0, 16'h0010}); end
        step();
        bus.ld_v_i = 1'b0;
        @(negedge clk_i);
        r = {bus.ld_resp_v_o, bus.ld_ready_o, bus.ld_resp_data_o};
        n_total++;
        if (r !== {1'b1, 1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL reset_first_resp: got %h want %h", r, {1'b1, 1'b0, 16'hBEEF}); end
        step();
        @(negedge clk_i);
        o = all_outs();
        n_total++;
        if (o !== 53'd0) begin n_bad++; $display("FAIL idle_no_request: got %h want 0", o); end
        step();
    endtask

    task automatic test_starvation();
        int occ;
        logic [3:0] o, e;
        bit st_exp;
        drive_idle();
        step();
        occ = 5;
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0020;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h00B0; bus.st_data_i = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            bus.sb_occupancy_i = OW'(occ);
            @(negedge clk_i);
            st_exp = (k >= 4) && (k <= 6);
            e = st_exp ? 4'b0111 : 4'b1010;
            o = {bus.ld_ready_o, bus.st_ready_o, bus.mem_v_o, bus.mem_w_o};
            n_total++;
            if (o !== e) begin n_bad++; $display("FAIL starve_seq k=%0d: got %b want %b", k, o, e); end
            step();
            if (st_exp) occ--;
        end
        drive_idle();
        step();
    endtask

    task automatic test_high_water();
        logic [51:0] o, e;
        logic [1:0] g;
        drive_idle();
        step();
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0021;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h0090; bus.st_data_i = 16'h5A5A;
        bus.sb_occupancy_i = OW'(6);
        @(negedge clk_i);
        g = {bus.ld_ready_o, bus.st_ready_o};
        n_total++;
        if (g !== 2'b10) begin n_bad++; $display("FAIL hw_cycle0: got %b want 10", g); end
        step();
        @(negedge clk_i);
        o = {bus.st_ready_o, bus.mem_w_o, bus.ld_ready_o, bus.ld_resp_v_o, bus.mem_addr_o, bus.mem_data_o, bus.ld_resp_data_o};
        e = {1'b1, 1'b1, 1'b0, 1'b1, 16'h0090, 16'h5A5A, 16'h21DE};
        n_total++;
        if (o !== e) begin n_bad++; $display("FAIL hw_store_forced: got %h want %h", o, e); end
        drive_idle();
        step();
        step();
    endtask

    task automatic test_flush();
        logic [W+20:0] o, e;
        logic [1:0] q;
        drive_idle();
        step();
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0022;
        @(negedge clk_i);
        n_total++;
        if (bus.ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_grant: got %b want 1", bus.ld_ready_o); end
        step();
        bus.flush_i = 1'b1; bus.ld_addr_i = 16'h0023;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h00A0; bus.st_data_i = 16'h0F0F;
        bus.sb_occupancy_i = OW'(2);
        @(negedge clk_i);
        o = {bus.ld_resp_v_o, bus.ld_resp_data_o, bus.ld_ready_o, bus.st_ready_o, bus.mem_w_o,
             bus.mem_addr_o[3:0], 16'(bus.mem_data_o)};
        e = {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0F0F};
        n_total++;
        if (o !== e || bus.mem_addr_o !== 16'h00A0) begin
            n_bad++; $display("FAIL flush_cycle: got %h addr %h want %h addr 00a0", o, bus.mem_addr_o, e);
        end
        step();
        drive_idle();
        @(negedge clk_i);
        q = {bus.ld_resp_v_o, bus.mem_v_o};
        n_total++;
        if (q !== 2'b00) begin n_bad++; $display("FAIL flush_after: got %b want 00", q); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [52:0] o;
        logic [1:0] g, e;
        drive_idle();
        step();
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0024;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h00B4; bus.st_data_i = 16'h7777;
        bus.sb_occupancy_i = OW'(3);
        for (int k = 0; k < 3; k++) step();
        #1 reset_n_i = 1'b0;
        #1 o = all_outs();
        n_total++;
        if (o !== 53'd0) begin n_bad++; $display("FAIL reset_mid_async: got %h want 0", o); end
        #1 reset_n_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            e = (k < 4) ? 2'b10 : 2'b01;
            g = {bus.ld_ready_o, bus.st_ready_o};
            n_total++;
            if (g !== e) begin n_bad++; $display("FAIL reset_mid_after k=%0d: got %b want %b", k, g, e); end
            step();
        end
        drive_idle();
        step();
    endtask

    task automatic test_random();
        bit ldv, stv, fl, g_ld, g_st;
        int occ;
        logic [W-1:0] la, sa, sd, e_addr, e_data, e_rd;
        logic [52:0] o, e;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        drive_idle();
        reset_n_i = 1'b0;
        #2 reset_n_i = 1'b1;
        model_reset();
        step();
        for (int c = 0; c < 400; c++) begin
            ldv = ($urandom_range(0, 99) < 60);
            stv = ($urandom_range(0, 99) < 55);
            fl  = ($urandom_range(0, 9) == 0);
            occ = $urandom_range(0, SBE);
            la  = W'($urandom_range(0, 31));
            sa  = W'($urandom_range(0, 31));
            sd  = W'($urandom);
            bus.ld_v_i = ldv; bus.ld_addr_i = la;
            bus.st_v_i = stv; bus.st_addr_i = sa; bus.st_data_i = sd;
            bus.flush_i = fl; bus.sb_occupancy_i = OW'(occ);
            @(negedge clk_i);
            model_grant(ldv, stv, fl, g_ld, g_st);
            e_addr = g_st ? sa : (g_ld ? la : '0);
            e_data = g_st ? sd : '0;
            e_rd   = (m_pend && !fl) ? m_pend_data : '0;
            e = {g_ld, g_st, g_ld || g_st, g_st, e_addr, e_data, m_pend && !fl, e_rd};
            o = all_outs();
            n_total++;
            if (o !== e) begin n_bad++; $display("FAIL random c=%0d: got %h want %h", c, o, e); end
            @(posedge clk_i);
            model_clock(stv, occ, g_ld, g_st, la, sa, sd);
            #1;
        end
        drive_idle();
        step();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        logic [95:0] o, e;
        drive_idle();
        reset_n_i = 1'b0;
        #2 reset_n_i = 1'b1;
        step();
        bus.ld_v_i = 1'b1; bus.ld_addr_i = 16'h0030;
        bus.st_v_i = 1'b1; bus.st_addr_i = 16'h00C0; bus.st_data_i = 16'h1111;
        bus.sb_occupancy_i = OW'(3);
        for (int k = 0; k < 5; k++) step();
        bus.st_v_i = 1'b0;
        step();
        bus.ld_v_i = 1'b0; bus.st_v_i = 1'b1; bus.sb_occupancy_i = OW'(2);
        step();
        step();
        drive_idle();
        @(negedge clk_i);
        o = {perf_ld, perf_st, perf_fd};
        e = {32'd5, 32'd3, 32'd1};
        n_total++;
        if (o !== e) begin n_bad++; $display("FAIL perf_counts: got %h want %h", o, e); end
        step();
    endtask
`endif

    initial begin
        drive_idle();
        reset_n_i = 1'b0;
        test_reset();
        test_starvation();
        test_high_water();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
